// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash master between the instruction-fetch and data ports.
// Keeps an instruction read stream open so sequential fetches need only a cont pulse.
module spi_flash_arbiter #(
    parameter logic [7:0]  READ_CMD       = 8'h03,
    parameter logic [7:0]  WRITE_CMD      = 8'h02,
    parameter logic [5:0]  XFER_BITS      = 6'd32,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8191
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [23:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [23:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        timeout,
    output logic        m_start,
    output logic        m_stop,
    output logic        m_cont,
    output logic        m_write_enable,
    output logic        m_is_instr,
    output logic [31:0] m_cmd_addr,
    output logic [5:0]  m_data_len,
    output logic [31:0] m_data_in,
    input  logic [31:0] m_data_out,
    input  logic        m_done
);

    typedef enum logic [2:0] {
        IDLE, STREAM, STOP, ISSUE, WAIT, DRAIN
    } state_t;

    state_t      state, state_nx;
    logic        stream_open, last_d, cur_i;
    logic        stop_idle, cont_q, tstop_q;
    logic [23:0] next_addr;
    logic [15:0] wdog;
    logic        can_grant, grant_i, grant_d, any_grant;
    logic        hit, wd_expire, arb_state;

    // A requester still sees its ack this cycle, so it must not be re-granted.
    always_comb begin
        can_grant = !i_ack && !d_ack;
        grant_i   = can_grant && i_req && (!d_req || last_d);
        grant_d   = can_grant && d_req && (!i_req || !last_d);
        any_grant = grant_i || grant_d;
        arb_state = (state == IDLE) || (state == STREAM);
        hit       = (state == STREAM) && stream_open && grant_i
                    && (i_addr == next_addr);
        wd_expire = !m_done && (wdog == TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (any_grant) state_nx = ISSUE;
            STREAM: begin
                if (hit)            state_nx = WAIT;
                else if (any_grant) state_nx = STOP;
            end
            STOP:   if (stop_idle) state_nx = ISSUE;
            ISSUE:  state_nx = WAIT;
            WAIT: begin
                if (m_done)         state_nx = cur_i ? STREAM : DRAIN;
                else if (wd_expire) state_nx = DRAIN;
            end
            DRAIN:  if (!m_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_start    = (state == ISSUE);
        m_stop     = ((state == STOP) && !stop_idle) || tstop_q;
        m_cont     = cont_q;
        m_data_len = XFER_BITS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_ack          <= 1'b0;
            d_ack          <= 1'b0;
            i_rdata        <= '0;
            d_rdata        <= '0;
            timeout        <= 1'b0;
            m_cmd_addr     <= '0;
            m_is_instr     <= 1'b0;
            m_write_enable <= 1'b0;
            m_data_in      <= '0;
            stream_open    <= 1'b0;
            last_d         <= 1'b1;
            cur_i          <= 1'b0;
            stop_idle      <= 1'b0;
            cont_q         <= 1'b0;
            tstop_q        <= 1'b0;
            next_addr      <= '0;
            wdog           <= '0;
        end else begin
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            timeout   <= 1'b0;
            cont_q    <= 1'b0;
            tstop_q   <= 1'b0;
            stop_idle <= (state == STOP) && !stop_idle;
            wdog      <= (state == WAIT) ? wdog + 16'd1 : 16'd0;
            if (arb_state && any_grant) begin
                last_d <= grant_d;
                cur_i  <= grant_i;
                if (hit) begin
                    cont_q <= 1'b1;
                end else if (grant_i) begin
                    m_cmd_addr     <= {READ_CMD, i_addr};
                    m_is_instr     <= 1'b1;
                    m_write_enable <= 1'b0;
                end else begin
                    m_cmd_addr     <= {d_we ? WRITE_CMD : READ_CMD, d_addr};
                    m_is_instr     <= 1'b0;
                    m_write_enable <= d_we;
                    m_data_in      <= d_wdata;
                end
            end
            if (state == STOP) stream_open <= 1'b0;
            if (state == WAIT) begin
                if (m_done) begin
                    if (cur_i) begin
                        i_ack       <= 1'b1;
                        i_rdata     <= m_data_out;
                        next_addr   <= i_addr + 24'd4;
                        stream_open <= 1'b1;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= m_write_enable ? 32'd0 : m_data_out;
                    end
                end else if (wd_expire) begin
                    tstop_q     <= 1'b1;
                    timeout     <= 1'b1;
                    stream_open <= 1'b0;
                    if (cur_i) begin
                        i_ack   <= 1'b1;
                        i_rdata <= 32'hFFFF_FFFF;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= 32'hFFFF_FFFF;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter with a behavioural SPI master model.
// Request tables plus hand sequences for arbitration and the watchdog.
module tb_spi_flash_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [23:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [23:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        timeout;
    logic        m_start, m_stop, m_cont, m_write_enable, m_is_instr;
    logic [31:0] m_cmd_addr;
    logic [5:0]  m_data_len;
    logic [31:0] m_data_in;
    logic [31:0] m_data_out;
    logic        m_done;

    spi_flash_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .timeout(timeout),
        .m_start(m_start), .m_stop(m_stop), .m_cont(m_cont),
        .m_write_enable(m_write_enable), .m_is_instr(m_is_instr),
        .m_cmd_addr(m_cmd_addr), .m_data_len(m_data_len),
        .m_data_in(m_data_in), .m_data_out(m_data_out), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem(input logic [23:0] a);
        if (a == 24'h000100) return 32'hDEAD_BEEF;
        return {8'hC3 ^ a[7:0], a};
    endfunction

    // SPI master model: init delay on the first start after reset.
    logic        never_done = 1'b0;
    logic        busy, first, extra, is_i;
    int          cnt;
    logic [23:0] cur;
    logic [31:0] held;
    int          hold_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0; first <= 1'b1; extra <= 1'b0; is_i <= 1'b0;
            cnt <= 0; cur <= '0; held <= '0; hold_err <= 0;
            m_done <= 1'b0; m_data_out <= '0;
        end else if (m_start) begin
            busy <= 1'b1; cnt <= first ? 4096 : 3; first <= 1'b0;
            held <= m_cmd_addr; cur <= m_cmd_addr[23:0];
            is_i <= m_is_instr; m_done <= 1'b0;
        end else if (m_cont) begin
            busy <= 1'b1; cnt <= 3; cur <= cur + 24'd4; m_done <= 1'b0;
        end else if (m_stop) begin
            busy <= 1'b0; m_done <= 1'b0;
        end else if (busy) begin
            if (cnt != 0) cnt <= cnt - 1;
            else if (!never_done) begin
                m_done <= 1'b1; m_data_out <= mem(cur);
                extra <= !is_i; busy <= 1'b0;
                if (m_cmd_addr !== held) hold_err <= hold_err + 1;
            end
        end else if (m_done && extra) extra <= 1'b0;
        else m_done <= 1'b0;
    end

    // Monitors: pulse counts, protocol rules, scoreboard.
    int          cyc, n_start, n_cont, n_stop, n_to, viol;
    int          start_cyc, ack_cyc;
    logic        prev_pulse;
    logic [31:0] last_cmd, last_din;
    logic        last_instr, last_we;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb[$];
    sb_t e;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_start <= 0; n_cont <= 0; n_stop <= 0; n_to <= 0;
            prev_pulse <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            prev_pulse <= m_start | m_stop | m_cont;
            if (m_start) begin
                n_start <= n_start + 1; start_cyc <= cyc;
                last_cmd <= m_cmd_addr; last_din <= m_data_in;
                last_instr <= m_is_instr; last_we <= m_write_enable;
            end
            if (m_cont) n_cont <= n_cont + 1;
            if (m_stop) n_stop <= n_stop + 1;
            if (timeout) n_to <= n_to + 1;
            if ((32'(m_start) + 32'(m_stop) + 32'(m_cont) > 1) ||
                (prev_pulse && (m_start | m_stop | m_cont)) ||
                (i_ack && !i_req) || (d_ack && !d_req))
                viol <= viol + 1;
            if (i_ack || d_ack) ack_cyc <= cyc;
            if (i_ack) begin
                if (sb.size() == 0) chk("unexpected_i_ack", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("i_ack_source", 32'(e.is_d), 0);
                    chk("i_rdata", i_rdata, e.rdata);
                end
            end
            if (d_ack) begin
                if (sb.size() == 0) chk("unexpected_d_ack", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("d_ack_source", 32'(e.is_d), 1);
                    chk("d_rdata", d_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        cyc = 0; viol = 0; start_cyc = 0; ack_cyc = 0;
    end

    task automatic wait_ack(input bit is_d);
        bit got = 0;
        int n = 0;
        while (!got && n < 20000) begin
            @(negedge clk);
            if (is_d ? d_ack : i_ack) got = 1;
            n++;
        end
        if (!got) chk(is_d ? "d_ack_wait" : "i_ack_wait", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_fetch(input logic [23:0] a);
        @(posedge clk); #1;
        i_addr = a; i_req = 1'b1;
        wait_ack(0);
        i_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [23:0] a,
                           input logic [31:0] wd);
        @(posedge clk); #1;
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_ack(1);
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulses", {i_ack, d_ack, timeout, m_start, m_stop, m_cont,
                           m_write_enable, m_is_instr}, 0);
        chk("rst_cmd_addr", m_cmd_addr, 0);
        chk("rst_data_len", 32'(m_data_len), 32);
        chk("rst_rdata", i_rdata | d_rdata | m_data_in, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [23:0] addr;
        logic [31:0] wdata;
        int          n_start;
        int          n_cont;
        int          n_stop;
        logic [31:0] cmd;
    } vec_t;

    vec_t vt[9];
    int   s0, c0, p0, t0;

    initial begin
        vt[0] = '{0, 0, 24'h000100, 0, 1, 0, 0, 32'h0300_0100};
        vt[1] = '{0, 0, 24'h000104, 0, 0, 1, 0, 32'h0};
        vt[2] = '{0, 0, 24'h000200, 0, 1, 0, 1, 32'h0300_0200};
        vt[3] = '{1, 1, 24'h001000, 32'h1234_5678, 1, 0, 1, 32'h0200_1000};
        vt[4] = '{0, 0, 24'h000108, 0, 1, 0, 0, 32'h0300_0108};
        vt[5] = '{1, 0, 24'h002000, 0, 1, 0, 1, 32'h0300_2000};
        vt[6] = '{0, 0, 24'hFFFFFC, 0, 1, 0, 0, 32'h03FF_FFFC};
        vt[7] = '{0, 0, 24'h000000, 0, 0, 1, 0, 32'h0};
        vt[8] = '{0, 0, 24'h000004, 0, 0, 1, 0, 32'h0};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            s0 = n_start; c0 = n_cont; p0 = n_stop;
            sb.push_back('{vt[i].is_d,
                           (vt[i].is_d && vt[i].we) ? 32'd0 : mem(vt[i].addr)});
            if (vt[i].is_d) do_data(vt[i].we, vt[i].addr, vt[i].wdata);
            else            do_fetch(vt[i].addr);
            chk($sformatf("v%0d_starts", i), n_start - s0, vt[i].n_start);
            chk($sformatf("v%0d_conts", i), n_cont - c0, vt[i].n_cont);
            chk($sformatf("v%0d_stops", i), n_stop - p0, vt[i].n_stop);
            if (vt[i].n_start != 0) begin
                chk($sformatf("v%0d_cmd", i), last_cmd, vt[i].cmd);
                chk($sformatf("v%0d_is_instr", i), 32'(last_instr),
                    32'(!vt[i].is_d));
                chk($sformatf("v%0d_we", i), 32'(last_we), 32'(vt[i].we));
                if (vt[i].we)
                    chk($sformatf("v%0d_data_in", i), last_din, vt[i].wdata);
            end
        end
        chk("no_timeout_after_init", n_to, 0);

        // Simultaneous requests straight out of reset: instr wins first.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{0, mem(24'h000300 + 24'(r * 4))});
            sb.push_back('{1, mem(24'h003000 + 24'(r * 16))});
            fork
                do_fetch(24'h000300 + 24'(r * 4));
                do_data(0, 24'h003000 + 24'(r * 16), 0);
            join
        end
        chk("arb_sb_drained", sb.size(), 0);

        // Master never completes: watchdog aborts the fetch.
        never_done = 1'b1;
        s0 = n_start; p0 = n_stop; t0 = n_to;
        sb.push_back('{0, 32'hFFFF_FFFF});
        do_fetch(24'h000400);
        chk("to_starts", n_start - s0, 1);
        chk("to_stops", n_stop - p0, 1);
        chk("to_pulses", n_to - t0, 1);
        chk("to_latency_in_range",
            32'((ack_cyc - start_cyc >= 8191) && (ack_cyc - start_cyc <= 8200)), 1);
        never_done = 1'b0;

        // Stream was closed by the abort, so the next fetch needs a start.
        s0 = n_start; c0 = n_cont;
        sb.push_back('{0, mem(24'h000404)});
        do_fetch(24'h000404);
        chk("post_to_starts", n_start - s0, 1);
        chk("post_to_conts", n_cont - c0, 0);

        repeat (10) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("protocol_violations", viol, 0);
        chk("cmd_hold_errors", hold_err, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
